// File: rtl/tone_sequencer.sv
// Melody sequencer: walks a song table of (half-period, duration) pairs and
// feeds each note to the square-wave tone generator over a valid/ready handshake.
module tone_sequencer #(
  parameter int TICK_DIV = 50000,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [16:0]       wr_half,
  input  logic [11:0]       wr_dur,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [16:0]       tone_half,
  output logic              tone_valid,
  input  logic              tone_ready,
  output logic              gen_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] note_idx
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

  state_t state, state_next;

  logic [28:0]       song [DEPTH];
  logic [16:0]       ent_half;
  logic [11:0]       ent_dur;

  logic [11:0]       dur_q, dur_next;
  logic [PW-1:0]     presc, presc_next;
  logic [11:0]       ticks, ticks_next;
  logic [16:0]       half_next;
  logic [ADDR_W-1:0] idx_next;
  logic              valid_next, gen_next, done_next;
  logic              at_end;

  // Table is never reset so a song survives a reset of the sequencer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      song[wr_addr] <= {wr_half, wr_dur};
    end
  end

  assign {ent_half, ent_dur} = song[note_idx];
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      note_idx   <= '0;
      tone_half  <= '0;
      tone_valid <= 1'b0;
      gen_en     <= 1'b0;
      done       <= 1'b0;
      dur_q      <= '0;
      presc      <= '0;
      ticks      <= '0;
    end else begin
      state      <= state_next;
      note_idx   <= idx_next;
      tone_half  <= half_next;
      tone_valid <= valid_next;
      gen_en     <= gen_next;
      done       <= done_next;
      dur_q      <= dur_next;
      presc      <= presc_next;
      ticks      <= ticks_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = note_idx;
    half_next  = tone_half;
    valid_next = tone_valid;
    gen_next   = gen_en;
    done_next  = 1'b0;
    dur_next   = dur_q;
    presc_next = presc;
    ticks_next = ticks;
    at_end     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          idx_next   = '0;
        end
      end
      FETCH: begin
        half_next = ent_half;
        dur_next  = ent_dur;
        if (ent_dur == 12'd0) begin
          at_end = 1'b1;
        end else if (ent_half == 17'd0) begin
          gen_next   = 1'b0;
          state_next = PLAY;
          presc_next = '0;
          ticks_next = '0;
        end else begin
          valid_next = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (tone_ready) begin
          valid_next = 1'b0;
          gen_next   = 1'b1;
          state_next = PLAY;
          presc_next = '0;
          ticks_next = '0;
        end
      end
      PLAY: begin
        if (presc == PRESC_LAST) begin
          presc_next = '0;
          ticks_next = ticks + 12'd1;
          if (ticks + 12'd1 == dur_q) begin
            if (note_idx == LAST_IDX) begin
              at_end = 1'b1;
            end else begin
              idx_next   = note_idx + 1'b1;
              state_next = FETCH;
            end
          end
        end else begin
          presc_next = presc + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Looping back from entry 0 is refused so an empty song cannot spin forever.
    if (at_end) begin
      if (loop_en && note_idx != '0) begin
        idx_next   = '0;
        state_next = FETCH;
      end else begin
        done_next  = 1'b1;
        gen_next   = 1'b0;
        valid_next = 1'b0;
        state_next = IDLE;
      end
    end

    if (stop) begin
      state_next = IDLE;
      idx_next   = note_idx;
      gen_next   = 1'b0;
      valid_next = 1'b0;
      done_next  = 1'b0;
      presc_next = '0;
      ticks_next = '0;
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: expected tone half-periods are queued when a
// song is started and checked as each valid/ready handshake happens.
module tb_tone_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [16:0] wr_half;
  logic [11:0] wr_dur;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [16:0] tone_half;
  logic        tone_valid;
  logic        tone_ready;
  logic        gen_en;
  logic        busy;
  logic        done;
  logic [3:0]  note_idx;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_count   = 0;
  logic [16:0] exp_q[$];
  logic [16:0] exp_h;

  tone_sequencer #(.TICK_DIV(4), .DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_half(wr_half), .wr_dur(wr_dur), .start(start), .stop(stop),
    .loop_en(loop_en), .tone_half(tone_half), .tone_valid(tone_valid),
    .tone_ready(tone_ready), .gen_en(gen_en), .busy(busy), .done(done),
    .note_idx(note_idx)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic p);
    start = s;
    stop  = p;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic writeEntry(input logic [3:0] a, input logic [16:0] h, input logic [11:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_half = h;
    wr_dur  = d;
    tick(1);
    wr_en   = 1'b0;
  endtask

  // Scoreboard: every accepted tone must match the next queued half-period.
  always @(negedge clk) begin
    if (rst_n && tone_valid && tone_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("handshake_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_h = exp_q.pop_front();
        checkOutput("handshake_half", 32'(tone_half), 32'(exp_h));
      end
    end
    if (done) done_count++;
  end

  initial begin
    int hi, lo, seen, seen_hi, n, last, dc;
    int seq [7];
    int exp_seq [7] = '{0, 1, 2, 0, 1, 2, 0};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_half = '0; wr_dur = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0; tone_ready = 1'b1;
    tick(3);
    checkOutput("reset_outputs", 32'({tone_half, tone_valid, gen_en, busy, done, note_idx}), 32'd0);
    rst_n = 1'b1;

    // Two tones then an end marker.
    writeEntry(4'd0, 17'd100, 12'd2);
    writeEntry(4'd1, 17'd200, 12'd1);
    writeEntry(4'd2, 17'd77,  12'd0);
    exp_q.push_back(17'd100);
    exp_q.push_back(17'd200);
    applyStimulus(1'b1, 1'b0);
    checkOutput("s1_busy_fetch", 32'({busy, tone_valid, gen_en}), 32'b100);
    tick(1);
    checkOutput("s1_load", 32'({tone_valid, tone_half}), 32'({1'b1, 17'd100}));
    tick(1);
    checkOutput("s1_play_entry", 32'({gen_en, tone_valid}), 32'b10);
    hi = 0; lo = 0; seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin seen = 1; break; end
      if (gen_en) hi++; else lo++;
      tick(1);
    end
    checkOutput("s1_done_seen", 32'(seen), 32'd1);
    checkOutput("s1_gen_cycles", 32'(hi), 32'd15);
    checkOutput("s1_gen_gaps", 32'(lo), 32'd0);
    checkOutput("s1_end_state", 32'({busy, gen_en, tone_valid, note_idx}), 32'({3'b000, 4'd2}));
    tick(1);
    checkOutput("s1_done_width", 32'(done), 32'd0);
    checkOutput("s1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Stalled handshake, then stop mid-PLAY.
    tone_ready = 1'b0;
    exp_q.push_back(17'd100);
    dc = done_count;
    applyStimulus(1'b1, 1'b0);
    tick(1);
    checkOutput("s2_load0", 32'({tone_valid, gen_en, tone_half}), 32'({2'b10, 17'd100}));
    for (int k = 0; k < 5; k++) begin
      tick(1);
      checkOutput("s2_stall", 32'({tone_valid, gen_en, tone_half}), 32'({2'b10, 17'd100}));
    end
    tone_ready = 1'b1;
    tick(1);
    checkOutput("s2_play", 32'({gen_en, tone_valid}), 32'b10);
    tick(2);
    applyStimulus(1'b0, 1'b1);
    checkOutput("s2_stop", 32'({busy, gen_en, tone_valid, done, note_idx}), 32'd0);
    tick(3);
    checkOutput("s2_no_done", 32'(done_count), 32'(dc));
    checkOutput("s2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Rest between two tones: 12 rest cycles plus the next tone's FETCH and LOAD.
    writeEntry(4'd0, 17'd100, 12'd1);
    writeEntry(4'd1, 17'd0,   12'd3);
    writeEntry(4'd2, 17'd200, 12'd1);
    writeEntry(4'd3, 17'd5,   12'd0);
    exp_q.push_back(17'd100);
    exp_q.push_back(17'd200);
    applyStimulus(1'b1, 1'b0);
    seen = 0; seen_hi = 0; lo = 0;
    for (int k = 0; k < 60; k++) begin
      if (done) begin seen = 1; break; end
      if (gen_en) seen_hi = 1;
      else if (seen_hi != 0) lo++;
      tick(1);
    end
    checkOutput("s3_done_seen", 32'(seen), 32'd1);
    checkOutput("s3_rest_low", 32'(lo), 32'd14);
    checkOutput("s3_note_idx", 32'(note_idx), 32'd3);
    checkOutput("s3_queue_empty", 32'(exp_q.size()), 32'd0);

    // Looping song: index walks 0,1,2,0,1,2,0 without a done pulse.
    writeEntry(4'd0, 17'd100, 12'd1);
    writeEntry(4'd1, 17'd200, 12'd1);
    writeEntry(4'd2, 17'd9,   12'd0);
    loop_en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(17'd100);
      exp_q.push_back(17'd200);
    end
    dc = done_count;
    applyStimulus(1'b1, 1'b0);
    seq[0] = int'(note_idx); n = 1; last = int'(note_idx);
    for (int k = 0; k < 100 && n < 7; k++) begin
      tick(1);
      if (int'(note_idx) != last) begin
        seq[n] = int'(note_idx);
        last = int'(note_idx);
        n++;
      end
    end
    applyStimulus(1'b0, 1'b1);
    checkOutput("s4_seq_len", 32'(n), 32'd7);
    for (int i = 0; i < 7; i++) checkOutput("s4_seq", 32'(seq[i]), 32'(exp_seq[i]));
    checkOutput("s4_no_done", 32'(done_count), 32'(dc));
    checkOutput("s4_queue_empty", 32'(exp_q.size()), 32'd0);

    // End marker at entry 0 finishes even with looping enabled.
    writeEntry(4'd0, 17'd55, 12'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("s5_fetch", 32'({busy, done}), 32'b10);
    tick(1);
    checkOutput("s5_done", 32'({busy, done, gen_en, note_idx}), 32'({3'b010, 4'd0}));

    // Start and stop together in IDLE: stop wins.
    applyStimulus(1'b1, 1'b1);
    checkOutput("s6_combined", 32'({busy, done, gen_en, tone_valid}), 32'd0);
    tick(1);
    checkOutput("s6_still_idle", 32'(busy), 32'd0);

    // Full table, rewrite of the playing entry shows up only on the next pass.
    for (int i = 0; i < 16; i++) writeEntry(4'(i), 17'(10 + i), 12'd1);
    for (int i = 0; i < 16; i++) exp_q.push_back(17'(10 + i));
    exp_q.push_back(17'd10);
    exp_q.push_back(17'd999);
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < 30; k++) begin
      if (note_idx == 4'd1) break;
      tick(1);
    end
    checkOutput("s7_reached_idx1", 32'(note_idx), 32'd1);
    tick(2);
    writeEntry(4'd1, 17'd999, 12'd1);
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0) break;
      tick(1);
    end
    checkOutput("s7_pass_queue", 32'(exp_q.size()), 32'd0);
    tone_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (tone_valid) break;
      tick(1);
    end
    checkOutput("s7_load_idx2", 32'({tone_valid, note_idx, tone_half}), 32'({1'b1, 4'd2, 17'd12}));
    rst_n = 1'b0;
    tick(1);
    checkOutput("s7_reset_mid_load", 32'({tone_half, tone_valid, gen_en, busy, done, note_idx}), 32'd0);
    rst_n = 1'b1;
    tone_ready = 1'b1;
    loop_en = 1'b0;
    exp_q.push_back(17'd10);
    exp_q.push_back(17'd999);
    for (int i = 2; i < 16; i++) exp_q.push_back(17'(10 + i));
    applyStimulus(1'b1, 1'b0);
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      if (done) begin seen = 1; break; end
      tick(1);
    end
    checkOutput("s7_done_seen", 32'(seen), 32'd1);
    checkOutput("s7_final_idx", 32'({busy, gen_en, note_idx}), 32'({2'b00, 4'd15}));
    checkOutput("s7_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
